beep_sequencer: RTL and testbench
=================================

// Module: beep_sequencer
// PURPOSE
// - Microwave buzzer controller: on a start pulse, plays NUM_BEEPS tone bursts separated by silent gaps.
// - Sequences an internal square-wave tone divider and gates the speaker output. Sits between the cook-timer FSM and the speaker pin.
// - A front-panel key press (ack) silences it at any time.
// PARAMETERS
// - MS_DIV      50000  clock cycles per 1 ms timebase tick (>=2)
// - TONE_DIV    25000  tone period in clock cycles (>=2, even); tone high for first TONE_DIV/2 cycles
// - BEEP_ON_MS  200    burst length in ms (>=1)
// - BEEP_OFF_MS 200    gap length in ms (>=1)
// - NUM_BEEPS   3      bursts per pattern (>=1)
// - REMIND_MS   10000  idle interval before pattern replay (used only with BEEP_REMINDER_EN)
// PORTS
// - clock_in     in   1  system clock
// - reset        in   1  synchronous reset, active-high
// - start        in   1  1-cycle pulse: begin pattern
// - ack          in   1  silence/abort request, level or pulse
// - speaker      out  1  gated tone to buzzer, registered
// - busy         out  1  high from cycle after accepted start until return to IDLE
// - done         out  1  1-cycle pulse when final burst ends naturally (not on ack)
// BEHAVIOUR
// - Clock and reset: one clock, clock_in. reset is synchronous and active-high. On reset: state=IDLE; speaker=0, busy=0, done=0; all counters cleared.
// - States: IDLE, ON, OFF, plus WAIT when BEEP_REMINDER_EN is defined.
// - IDLE->ON: on start. Load beeps_left=NUM_BEEPS. Clear ms prescaler and ms counter.
// - ON->OFF: after exactly BEEP_ON_MS*MS_DIV cycles in ON, if beeps_left>1. Decrement beeps_left.
// - ON->IDLE: on the same ON expiry when beeps_left==1. done=1 on the first IDLE cycle.
// - OFF->ON: after exactly BEEP_OFF_MS*MS_DIV cycles in OFF.
// - Every ON/OFF entry clears the prescaler, so durations are exact with no carry-over.
// - ack in any non-IDLE state: next state IDLE. speaker=0 and busy=0 the following cycle. No done pulse.
// - start with ack in the same cycle: ack wins, start is ignored.
// - start while busy: ignored, no restart.
// - Tone divider:
//   - Counts only in ON; cleared on every ON entry.
//   - tone=1 while count<TONE_DIV/2. Count wraps at TONE_DIV-1.
// - speaker = registered (state==ON & tone).
//   - First high cycle is 1 cycle after entering ON.
//   - Forced 0 in all other states.
// - busy = registered (state!=IDLE).
// - Widths:
//   - Counters sized with $clog2 of their maximum value.
//   - beeps_left width is $clog2(NUM_BEEPS+1).
//   - No counter may overflow at any legal parameter value.
// CONFIGURATION
// - BEEP_REMINDER_EN defined:
//   - Natural pattern end goes ON->WAIT (not IDLE); done still pulses.
//   - After REMIND_MS ms in WAIT, go ON with beeps_left=NUM_BEEPS.
//   - busy stays 1 in WAIT. Only ack or reset returns to IDLE.
// - BEEP_REMINDER_EN undefined: WAIT and its counter logic are absent; behaviour exactly as above.
// STRUCTURE
// - Package beep_pkg holds:
//   - state enum beep_state_t (IDLE, ON, OFF, WAIT)
//   - localparam width helpers for the ms, tone and beep counters
// - One sub-module, tone_divider: inputs clock_in, reset, en, clr; parameter DIV; output tone.
// - Top level holds the FSM, ms prescaler, ms counter, beep counter and output registers.
// TESTING
// - Bench parameters: MS_DIV=4, TONE_DIV=4, BEEP_ON_MS=2, BEEP_OFF_MS=1, NUM_BEEPS=2, REMIND_MS=3.
// - T1 reset: assert reset 3 cycles -> speaker=0, busy=0, done=0. Outputs stay 0 with no start.
// - T2 full pattern: start at cycle k ->
//   - busy 1 from k+2 to k+21
//   - speaker toggles 2-high/2-low in bursts k+2..k+9 and k+14..k+21
//   - done pulses once at k+22
// - T3 abort: ack 5 cycles after start -> speaker=0 and busy=0 two cycles later. done never pulses.
// - T4 collisions:
//   - start+ack in the same cycle -> stays IDLE.
//   - second start mid-pattern -> timing identical to T2.
// - T5 reset mid-OFF -> next cycle all outputs 0. A new start then reproduces T2 exactly.
// - T6 with BEEP_REMINDER_EN:
//   - after done, 12 cycles of silence with busy=1, then T2 burst timing repeats.
//   - ack during WAIT -> IDLE.

Source files
------------

// File: rtl/beep_pkg.sv
// Shared types and width helpers for the beep sequencer and its tone divider.
package beep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    WAIT = 2'd3
  } beep_state_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/beep_sequencer_tone_divider.sv
// Square-wave tone source: high for the first DIV/2 cycles of each DIV-cycle period.
module tone_divider
  import beep_pkg::*;
#(
  parameter int DIV = 25000
) (
  input  logic clock_in,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tone
);

  localparam int CW = cnt_w(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; all next-state math lives in always_comb.
  always_ff @(posedge clock_in) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tone = (cnt_q < CW'(DIV / 2));

endmodule

// File: rtl/beep_sequencer.sv
// Buzzer pattern controller: NUM_BEEPS tone bursts separated by gaps, abortable by ack.
// Optional feature macro BEEP_REMINDER_EN replays the pattern every REMIND_MS ms until ack.
module beep_sequencer
  import beep_pkg::*;
#(
  parameter int MS_DIV      = 50000,
  parameter int TONE_DIV    = 25000,
  parameter int BEEP_ON_MS  = 200,
  parameter int BEEP_OFF_MS = 200,
  parameter int NUM_BEEPS   = 3,
  parameter int REMIND_MS   = 10000
) (
  input  logic clock_in,
  input  logic reset,
  input  logic start,
  input  logic ack,
  output logic speaker,
  output logic busy,
  output logic done
);

`ifdef BEEP_REMINDER_EN
  localparam int MS_MAX = max2(max2(BEEP_ON_MS, BEEP_OFF_MS), REMIND_MS);
`else
  localparam int MS_MAX = max2(BEEP_ON_MS, BEEP_OFF_MS);
`endif
  localparam int PRE_W  = cnt_w(MS_DIV - 1);
  localparam int MS_W   = cnt_w(MS_MAX - 1);
  localparam int BEEP_W = $clog2(NUM_BEEPS + 1);

  beep_state_t       state_q, state_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [MS_W-1:0]   ms_q, ms_d;
  logic [BEEP_W-1:0] beeps_q, beeps_d;
  logic              fin_q, fin_d;
  logic              speaker_q, speaker_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ms_tick;
  logic              tone;
  logic              tone_clr;

  assign ms_tick = (pre_q == PRE_W'(MS_DIV - 1));

  always_comb begin
    state_d = state_q;
    beeps_d = beeps_q;
    fin_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !ack) begin
          state_d = ON;
          beeps_d = BEEP_W'(NUM_BEEPS);
        end
      end
      ON: begin
        if (ms_tick && ms_q == MS_W'(BEEP_ON_MS - 1)) begin
          if (beeps_q > BEEP_W'(1)) begin
            state_d = OFF;
            beeps_d = beeps_q - BEEP_W'(1);
          end else begin
            fin_d = 1'b1;
`ifdef BEEP_REMINDER_EN
            state_d = WAIT;
`else
            state_d = IDLE;
`endif
          end
        end
      end
      OFF: begin
        if (ms_tick && ms_q == MS_W'(BEEP_OFF_MS - 1)) state_d = ON;
      end
`ifdef BEEP_REMINDER_EN
      WAIT: begin
        if (ms_tick && ms_q == MS_W'(REMIND_MS - 1)) begin
          state_d = ON;
          beeps_d = BEEP_W'(NUM_BEEPS);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // Abort has priority over every natural transition, including the final one.
    if (ack && state_q != IDLE) begin
      state_d = IDLE;
      fin_d   = 1'b0;
    end
  end

  // Timebase restarts on every state change so each interval is exact.
  always_comb begin
    pre_d = pre_q;
    ms_d  = ms_q;
    if (state_d != state_q || state_q == IDLE) begin
      pre_d = '0;
      ms_d  = '0;
    end else if (ms_tick) begin
      pre_d = '0;
      ms_d  = ms_q + MS_W'(1);
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  assign tone_clr  = (state_d == ON) && (state_q != ON);
  assign speaker_d = (state_q == ON) && tone;
  assign busy_d    = (state_q != IDLE);
  assign done_d    = fin_q;

  // NOTE: every flop, counters included, is cleared by reset; none of this is memory.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      ms_q      <= '0;
      beeps_q   <= '0;
      fin_q     <= 1'b0;
      speaker_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      ms_q      <= ms_d;
      beeps_q   <= beeps_d;
      fin_q     <= fin_d;
      speaker_q <= speaker_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  tone_divider #(
    .DIV (TONE_DIV)
  ) u_tone (
    .clock_in (clock_in),
    .reset    (reset),
    .en       (state_q == ON),
    .clr      (tone_clr),
    .tone     (tone)
  );

  assign speaker = speaker_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_beep_sequencer.sv
// Directed bench for beep_sequencer with tiny timing parameters; define BEEP_REMINDER_EN to cover WAIT.
module tb_beep_sequencer;

  logic clock_in = 1'b0;
  logic reset    = 1'b0;
  logic start    = 1'b0;
  logic ack      = 1'b0;
  logic speaker, busy, done;

  int passed = 0;
  int total  = 0;

  beep_sequencer #(
    .MS_DIV      (4),
    .TONE_DIV    (4),
    .BEEP_ON_MS  (2),
    .BEEP_OFF_MS (1),
    .NUM_BEEPS   (2),
    .REMIND_MS   (3)
  ) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .start    (start),
    .ack      (ack),
    .speaker  (speaker),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock_in = ~clock_in;

  // Expected {speaker, busy, done} c cycles after the cycle carrying start.
  function automatic logic [2:0] exp_out(input int c);
    logic s, b, d;
    s = ((c >= 2 && c <= 9) || (c >= 14 && c <= 21)) && (((c - 2) % 4) < 2);
`ifdef BEEP_REMINDER_EN
    b = (c >= 2);
`else
    b = (c >= 2 && c <= 21);
`endif
    d = (c == 22);
    return {s, b, d};
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clock_in);
  endtask

  task automatic go_idle();
    ack = 1'b1;
    @(negedge clock_in);
    ack = 1'b0;
    idle_cycles(3);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_cycles(3);
    reset = 1'b0;
    total++;
    if ({speaker, busy, done} !== 3'b000)
      $display("FAIL reset_state: got %b want 000", {speaker, busy, done});
    else passed++;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock_in);
      total++;
      if ({speaker, busy, done} !== 3'b000)
        $display("FAIL reset_quiet c=%0d: got %b want 000", c, {speaker, busy, done});
      else passed++;
    end
  endtask

  task automatic test_full_pattern();
    start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clock_in);
      start = 1'b0;
      total++;
      if ({speaker, busy, done} !== exp_out(c))
        $display("FAIL full_pattern c=%0d: got %b want %b", c, {speaker, busy, done}, exp_out(c));
      else passed++;
    end
    go_idle();
  endtask

  task automatic test_abort();
    logic [2:0] exp;
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock_in);
      start = 1'b0;
      ack   = (c == 5);
      exp   = (c <= 6) ? exp_out(c) : 3'b000;
      total++;
      if ({speaker, busy, done} !== exp)
        $display("FAIL abort c=%0d: got %b want %b", c, {speaker, busy, done}, exp);
      else passed++;
    end
    ack = 1'b0;
  endtask

  task automatic test_collisions();
    start = 1'b1;
    ack   = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock_in);
      start = 1'b0;
      ack   = 1'b0;
      total++;
      if ({speaker, busy, done} !== 3'b000)
        $display("FAIL start_ack c=%0d: got %b want 000", c, {speaker, busy, done});
      else passed++;
    end
    start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clock_in);
      start = (c == 10 || c == 15);
      total++;
      if ({speaker, busy, done} !== exp_out(c))
        $display("FAIL restart_ignored c=%0d: got %b want %b", c, {speaker, busy, done}, exp_out(c));
      else passed++;
    end
    start = 1'b0;
    go_idle();
  endtask

  task automatic test_reset_mid_off();
    start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clock_in);
      start = 1'b0;
      reset = (c == 10);
      if (c >= 11) begin
        total++;
        if ({speaker, busy, done} !== 3'b000)
          $display("FAIL reset_mid_off c=%0d: got %b want 000", c, {speaker, busy, done});
        else passed++;
      end
    end
    reset = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clock_in);
      start = 1'b0;
      total++;
      if ({speaker, busy, done} !== exp_out(c))
        $display("FAIL post_reset_pattern c=%0d: got %b want %b", c, {speaker, busy, done}, exp_out(c));
      else passed++;
    end
    go_idle();
  endtask

`ifdef BEEP_REMINDER_EN
  task automatic test_reminder();
    logic [2:0] exp;
    start = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clock_in);
      start = 1'b0;
      ack   = (c == 60);
      if (c <= 32)      exp = exp_out(c);
      else if (c <= 61) exp = exp_out(c - 32) | 3'b010;
      else              exp = 3'b000;
      total++;
      if ({speaker, busy, done} !== exp)
        $display("FAIL reminder c=%0d: got %b want %b", c, {speaker, busy, done}, exp);
      else passed++;
    end
    ack = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_full_pattern();
    test_abort();
    test_collisions();
    test_reset_mid_off();
`ifdef BEEP_REMINDER_EN
    test_reminder();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
